// File: rtl/smem_pkg.sv
// Shared definitions for the SMEM backward K/L stage.
//   - token status codes
//   - slot state encoding
//   - kl_calc: backward k/l bounds adjusted around primary
//   - line_addr: cache-line request address from a k/l bound
// Arithmetic is carried in 64 bits and masked to the caller's SA width, so
// any SA_W up to 64 wraps exactly as a native SA_W-bit datapath would.
package smem_pkg;

  localparam logic [5:0] F_INIT  = 6'h00;
  localparam logic [5:0] F_RUN   = 6'h01;
  localparam logic [5:0] F_BREAK = 6'h02;
  localparam logic [5:0] BCK_INI = 6'h04;
  localparam logic [5:0] BCK_RUN = 6'h05;
  localparam logic [5:0] BCK_END = 6'h06;
  localparam logic [5:0] BUBBLE  = 6'h30;

  typedef enum logic {S_EMPTY, S_LOADED} slot_t;

  typedef struct packed {
    logic [63:0] k;
    logic [63:0] l;
  } kl_t;

  // kt = x0-1, lt = kt+x2; each bound steps down once more when it lies at or
  // past primary (the sentinel row is not stored in the occurrence table).
  function automatic kl_t kl_calc(input logic [63:0] x0, input logic [63:0] x2,
                                  input logic [63:0] primary, input logic [63:0] mask);
    logic [63:0] kt, lt;
    kl_t r;
    kt  = (x0 - 64'd1) & mask;
    lt  = (kt + x2) & mask;
    r.k = (kt >= primary) ? ((kt - 64'd1) & mask) : kt;
    r.l = (lt >= primary) ? ((lt - 64'd1) & mask) : lt;
    return r;
  endfunction

  // Drop the in-line offset, keep `bits` of line index, pad below with zeros.
  function automatic logic [63:0] line_addr(input logic [63:0] v, input int shift,
                                            input int bits, input int pad);
    logic [63:0] idx;
    idx = (v >> shift) & ((64'd1 << bits) - 64'd1);
    return idx << pad;
  endfunction

endpackage

// File: rtl/cal_kl_req_credit.sv
// req_credit_ctr: outstanding-request credit counter and request mask.
//   clk, rst      clock, async active-low reset
//   req_raw       slot wants to issue a request
//   req_ready     memory channel ready
//   rsp_ack       one completed request (returns a credit)
//   req_valid     request presented to memory (req_raw unless out of credit)
//   req_fire      request handshake completes this cycle
module req_credit_ctr #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_raw,
  input  logic req_ready,
  input  logic rsp_ack,
  output logic req_valid,
  output logic req_fire
);

  logic [CNT_W-1:0] cnt;
  logic             full, dec;

  // A same-cycle ack frees the credit this request would need.
  assign full      = (cnt == CNT_W'(MAX_OUT));
  assign req_valid = req_raw & ~(full & ~rsp_ack);
  assign req_fire  = req_valid & req_ready;
  // Acks with nothing outstanding are dropped rather than underflowing.
  assign dec       = rsp_ack & (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (req_fire & ~dec) cnt <= cnt + CNT_W'(1);
    else if (dec & ~req_fire) cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/cal_kl_req.sv
// cal_kl_req: backward K/L calculation stage of the SMEM pipeline.
// Takes one interval token, computes k/l around primary, issues one or two
// occurrence-table line reads (one when k and l share a line) under credit
// control, and forwards the token downstream.
//   in_*   : input token handshake and fields
//   out_*  : registered output token handshake and fields
//   req_*  : memory line-read request channel
//   rsp_ack: one pulse per completed memory request
module cal_kl_req
  import smem_pkg::*;
#(
  parameter int SA_W       = 64,
  parameter int SZ_W       = 7,
  parameter int META_W     = 128,
  parameter int ADDR_W     = 42,
  parameter int LINE_SHIFT = 7,
  parameter int LINE_BITS  = 28,
  parameter int LINE_PAD   = 4,
  parameter int MAX_OUT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_status,
  input  logic              in_finish,
  input  logic [SA_W-1:0]   in_x0,
  input  logic [SA_W-1:0]   in_x1,
  input  logic [SA_W-1:0]   in_x2,
  input  logic [SA_W-1:0]   in_info,
  input  logic [SA_W-1:0]   in_primary,
  input  logic [SZ_W-1:0]   in_mem_wr_addr,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_status,
  output logic [SA_W-1:0]   out_k,
  output logic [SA_W-1:0]   out_l,
  output logic [SA_W-1:0]   out_x0,
  output logic [SA_W-1:0]   out_x1,
  output logic [SA_W-1:0]   out_x2,
  output logic [SA_W-1:0]   out_info,
  output logic [SA_W-1:0]   out_primary,
  output logic [SZ_W-1:0]   out_mem_size,
  output logic              out_finish,
  output logic [META_W-1:0] out_meta,
  output logic              out_same_line,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_ack
);

  localparam logic [63:0] SA_MASK = 64'((65'd1 << SA_W) - 65'd1);

  slot_t             state_q, state_d;
  logic              out_pend;     // token not yet taken downstream
  logic [1:0]        req_left;     // requests still to issue (2 = k next)
  logic [5:0]        eff_status;
  logic              is_bck, is_end, keep, load;
  logic              in_fire, out_fire, req_fire, req_raw;
  logic              out_done, req_done, retire;
  kl_t               kl;
  logic [SA_W-1:0]   new_k, new_l;
  logic              new_same;
  logic [META_W-1:0] end_meta;

  // ---------------- input decode / k,l compute ----------------
  assign eff_status = in_finish ? BCK_END : in_status;
  assign is_bck     = (eff_status == BCK_INI) || (eff_status == BCK_RUN);
  assign is_end     = (eff_status == BCK_END);
  assign keep       = is_bck | is_end;   // other statuses are swallowed

  assign kl       = kl_calc(64'(in_x0), 64'(in_x2), 64'(in_primary), SA_MASK);
  assign new_k    = SA_W'(kl.k);
  assign new_l    = SA_W'(kl.l);
  assign new_same = line_addr(64'(new_k), LINE_SHIFT, LINE_BITS, LINE_PAD) ==
                    line_addr(64'(new_l), LINE_SHIFT, LINE_BITS, LINE_PAD);

  // Finish tokens carry only read_num through.
  always_comb begin
    end_meta      = '0;
    end_meta[8:0] = in_meta[8:0];
  end

  // ---------------- handshakes ----------------
  assign out_valid = (state_q == S_LOADED) & out_pend;
  assign req_raw   = (state_q == S_LOADED) & (req_left != 2'd0);
  assign out_fire  = out_valid & out_ready;

  // The two completion conditions are independent; the slot frees once both hold.
  assign out_done  = ~out_pend | out_fire;
  assign req_done  = (req_left == 2'd0) | ((req_left == 2'd1) & req_fire);
  assign retire    = (state_q == S_LOADED) & out_done & req_done;
  assign in_ready  = (state_q == S_EMPTY) | retire;
  assign in_fire   = in_valid & in_ready;
  assign load      = in_fire & keep;

  // For a merged token l shares k's line, so l-side addressing covers both.
  assign req_addr = ADDR_W'(line_addr(64'((req_left == 2'd2) ? out_k : out_l),
                                      LINE_SHIFT, LINE_BITS, LINE_PAD));

  req_credit_ctr #(.MAX_OUT(MAX_OUT)) u_credit (
    .clk      (clk),
    .rst      (rst),
    .req_raw  (req_raw),
    .req_ready(req_ready),
    .rsp_ack  (rsp_ack),
    .req_valid(req_valid),
    .req_fire (req_fire)
  );

  // ---------------- slot FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:  if (load)   state_d = S_LOADED;
      S_LOADED: if (retire) state_d = load ? S_LOADED : S_EMPTY;
      default:              state_d = S_EMPTY;
    endcase
  end

  // ---------------- token registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pend      <= 1'b0;
      req_left      <= 2'd0;
      out_status    <= BUBBLE;
      out_finish    <= 1'b0;
      out_mem_size  <= '0;
      out_k         <= '0;
      out_l         <= '0;
      out_x0        <= '0;
      out_x1        <= '0;
      out_x2        <= '0;
      out_info      <= '0;
      out_primary   <= '0;
      out_meta      <= '0;
      out_same_line <= 1'b0;
    end else if (load) begin
      out_pend      <= 1'b1;
      req_left      <= is_end ? 2'd0 : (new_same ? 2'd1 : 2'd2);
      out_status    <= is_end ? BUBBLE : BCK_RUN;
      out_finish    <= is_end;
      out_mem_size  <= (eff_status == BCK_INI) ? '0 : in_mem_wr_addr;
      out_k         <= is_end ? '0 : new_k;
      out_l         <= is_end ? '0 : new_l;
      out_x0        <= is_end ? '0 : in_x0;
      out_x1        <= is_end ? '0 : in_x1;
      out_x2        <= is_end ? '0 : in_x2;
      out_info      <= is_end ? '0 : in_info;
      out_primary   <= is_end ? '0 : in_primary;
      out_meta      <= is_end ? end_meta : in_meta;
      out_same_line <= is_end ? 1'b0 : new_same;
    end else begin
      if (out_fire) out_pend <= 1'b0;
      if (req_fire) req_left <= req_left - 2'd1;
    end
  end

endmodule

// File: doc/cal_kl_req.md
# cal_kl_req

Parametrised successor of the backward K/L calculation stage in the SMEM pipeline, between the read-queue parse stage and the occurrence-table memory interface. It accepts one interval token per handshake and computes the backward k/l bounds, adjusted around `primary`. It issues cache-line read requests over a ready/valid memory channel, merging the k and l requests when both fall on one line, and throttles them against a credit counter. The computed token is forwarded to the next stage over its own ready/valid handshake.

## Interface
Parameters:
- `SA_W`, 64: width of x0/x1/x2/info/primary/k/l.
- `SZ_W`, 7: width of memory-size fields.
- `META_W`, 128: opaque sideband bundle (read_num, i/j, output_c, addresses, min_intv, reserved tokens), passed through unchanged.
- `ADDR_W`, 42: request address width.
- `LINE_SHIFT`, 7: low bits of k/l dropped to form the line index.
- `LINE_BITS`, 28: line-index bits kept.
- `LINE_PAD`, 4: zero bits appended below the line index.
- `MAX_OUT`, 8: maximum outstanding memory requests (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_status` in 6, `in_finish` in 1: token state and finish flag.
- `in_x0`, `in_x1`, `in_x2`, `in_info`, `in_primary` in SA_W each: interval fields.
- `in_mem_wr_addr` in SZ_W: current memory write pointer.
- `in_meta` in META_W: sideband bundle.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_status` out 6: output token state.
- `out_k`, `out_l` out SA_W: computed bounds.
- `out_x0`, `out_x1`, `out_x2`, `out_info`, `out_primary` out SA_W: registered copies of the inputs.
- `out_mem_size` out SZ_W, `out_finish` out 1, `out_meta` out META_W, `out_same_line` out 1.
- `req_valid` out 1, `req_ready` in 1, `req_addr` out ADDR_W: memory request channel.
- `rsp_ack` in 1: one pulse per completed request; returns one credit.

## Operation
- Status codes: F_INIT=0x00, F_RUN=0x01, F_BREAK=0x02, BCK_INI=0x04, BCK_RUN=0x05, BCK_END=0x06, BUBBLE=0x30.
- Effective status: `in_finish` ? BCK_END : `in_status`.
- Arithmetic, modulo 2^SA_W:
  - kt = x0−1; lt = kt+x2.
  - k = (kt ≥ primary) ? kt−1 : kt; l = (lt ≥ primary) ? lt−1 : lt.
  - x0=0 gives kt = all-ones, so k = all-ones−1.
- Line address: `req_addr` = zero-extend({k[LINE_SHIFT+LINE_BITS−1:LINE_SHIFT], LINE_PAD'b0}), same form for l.
- Same-line merge: `out_same_line` = line(k)==line(l); a merged token issues only one request.
- Accepted token, by effective status:
  - BCK_INI: out_status=BCK_RUN, out_mem_size=0, two requests (k then l), or one if merged.
  - BCK_RUN: out_status=BCK_RUN, out_mem_size=in_mem_wr_addr, requests as for BCK_INI.
  - BCK_END: out_status=BUBBLE, out_finish=1, out_mem_size=in_mem_wr_addr, no requests. k, l, x*, primary and meta are zeroed; the meta[8:0] read_num field is kept.
  - Any other status (BUBBLE, forward states): consumed, dropped, no output.
- Slot FSM:
  - EMPTY → LOADED on in fire.
  - LOADED → EMPTY when the token has been accepted (out fire, now or earlier) and all its requests have fired.
  - The two conditions are tracked independently.
- `in_ready` = EMPTY, or (LOADED and the slot retires this cycle).
- Credit counter `cnt` (0..MAX_OUT):
  - +1 on req fire, −1 on `rsp_ack`; simultaneous events leave it unchanged.
  - `req_valid` is masked while cnt==MAX_OUT and no `rsp_ack` is present this cycle.
  - `rsp_ack` at cnt==0 is ignored (saturates).

## Timing
- Reset values: all outputs 0 except `out_status`=BUBBLE and `in_ready`=1; slot EMPTY; cnt=0.
- Reset mid-operation discards the pending token and its requests.
- Token accepted at edge N: `out_valid` and first `req_valid` asserted in cycle N+1.
- Second request goes out in the cycle after the first fires.
- Back-to-back throughput: 1 token per cycle for merged or finish tokens; 1 per 2 cycles for split tokens.
- `out_*` and `req_addr` remain stable while their valid is high and the corresponding ready is low.
- Full-throughput retire: out fire and last req fire in the same cycle as a new in fire. The slot reloads with no bubble.

## Structure
- Package `smem_pkg`: status localparams, a `kl_calc` function (kt/lt/primary adjust), and the line-address function.
- One sub-module, `req_credit_ctr` (counter plus mask); everything else stays in the top level.

## Test plan
- BCK_RUN, x0=0x100, x2=0x80, primary=0x50 → k=0xFE, l=0x17E, mem_size=in_mem_wr_addr; req_addr k line 0x10 and l line 0x20 (line index 1 and 2 after shift/pad).
- x0=0x10, x2=0x4, primary=0x1000, BCK_INI → k=0xF, l=0x13, same_line=1, exactly one request, mem_size=0.
- in_finish=1, read_num=0x1A5 → out_status=0x30, finish=1, no req_valid, meta[8:0]=0x1A5, other fields 0.
- MAX_OUT=2, req_ready=1, rsp_ack=0, three split tokens → exactly 2 req fires, then req_valid low; one rsp_ack → one further fire.
- out_ready held 0 for 5 cycles with requests done → outputs stable, in_ready=0; rsp_ack at cnt=0 leaves cnt=0.
- rst asserted while LOADED with one request pending → all outputs at reset values immediately, cnt=0, no further req_valid.
